// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state type, BCD digit width and DIGITS sizing helper
package bcd_pkg;
  localparam int BCD_W = 4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  function automatic int min_digits(input int width);
    longint unsigned m = (width >= 64) ? '1 : (64'd1 << width) - 64'd1;
    int n = 1;
    while (m >= 10) begin
      m = m / 10;
      n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: per-digit add-3 correction applied before each double-dabble shift
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [BCD_W*DIGITS-1:0] bcd_i,
  output logic [BCD_W*DIGITS-1:0] bcd_o
);
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [BCD_W-1:0] d;
    assign d = bcd_i[BCD_W*i +: BCD_W];
    assign bcd_o[BCD_W*i +: BCD_W] = (d >= BCD_W'(5)) ? d + BCD_W'(3) : d;
  end
endmodule

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: one-bit-per-clock binary-to-BCD converter with blanking mask
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [WIDTH-1:0]        value,
  output logic                    ready,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]       digit_en
);
  localparam int CW = $clog2(WIDTH + 1);

  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $error("bcd_seq_converter: DIGITS too small for WIDTH");
  end

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]          sh_q, sh_d;
  logic [BCD_W*DIGITS-1:0]   work_q, work_d, adj, bcd_q, bcd_d;
  logic [DIGITS-1:0]         en_q, en_d, en_w;
  logic                      done_q, done_d, nz;

  bcd_dabble_step #(.DIGITS(DIGITS)) u_step (
    .bcd_i(work_q),
    .bcd_o(adj)
  );

  // digit i lights when it or any more-significant digit is non-zero
  always_comb begin
    en_w = '0;
    nz = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      nz = nz | (|work_q[BCD_W*i +: BCD_W]);
      en_w[i] = nz;
    end
    en_w[0] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    work_d  = work_q;
    bcd_d   = bcd_q;
    en_d    = en_q;
    done_d  = state_q == DONE;
    case (state_q)
      IDLE: if (start) begin
        sh_d    = value;
        work_d  = '0;
        cnt_d   = CW'(WIDTH);
        state_d = SHIFT;
      end
      SHIFT: begin
        {work_d, sh_d} = {adj, sh_q} << 1;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? DONE : SHIFT;
      end
      DONE: begin
        bcd_d   = work_q;
        en_d    = en_w;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      work_q  <= '0;
      bcd_q   <= '0;
      en_q    <= DIGITS'(1);
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      work_q  <= work_d;
      bcd_q   <= bcd_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign ready    = state_q == IDLE;
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign digit_en = en_q;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: randomized checks of two converter sizes against a divide/modulo model
module tb_bcd_seq_converter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start_a, rdy_a, done_a, start_b, rdy_b, done_b;
  logic [7:0]  val_a;
  logic [11:0] bcd_a;
  logic [2:0]  en_a;
  logic [15:0] val_b;
  logic [19:0] bcd_b;
  logic [4:0]  en_b;

  int n_chk = 0, n_fail = 0;
  int dones, nxt, lat;
  logic exp_done;
  longint unsigned v;
  longint unsigned vq[$];
  int acc[$];
  logic [63:0] last_bcd, last_en;

  bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .reset_n(rst_n), .start(start_a), .value(val_a),
    .ready(rdy_a), .done(done_a), .bcd(bcd_a), .digit_en(en_a)
  );

  bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) u_b (
    .clk(clk), .reset_n(rst_n), .start(start_b), .value(val_b),
    .ready(rdy_b), .done(done_b), .bcd(bcd_b), .digit_en(en_b)
  );

  function automatic logic [63:0] ref_bcd(input longint unsigned x, input int nd);
    logic [63:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] ref_en(input longint unsigned x, input int nd);
    logic [63:0] e = 64'd1;
    longint unsigned p = 10;
    for (int i = 1; i < nd; i++) begin
      e[i] = (x / p) != 0;
      p = p * 10;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic conv_a(input logic [7:0] x);
    int l = -1;
    @(negedge clk); start_a = 1'b1; val_a = x;
    @(posedge clk); #1; start_a = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done_a) begin l = k; break; end
    end
    check("lat_a", l, 9);
    check("bcd_a", bcd_a, ref_bcd(x, 3));
    check("en_a", en_a, ref_en(x, 3));
    @(posedge clk); #1;
    check("rdy_a", rdy_a, 1);
    check("pulse_a", done_a, 0);
  endtask

  task automatic conv_b(input logic [15:0] x);
    int l = -1;
    @(negedge clk); start_b = 1'b1; val_b = x;
    @(posedge clk); #1; start_b = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done_b) begin l = k; break; end
    end
    check("lat_b", l, 17);
    check("bcd_b", bcd_b, ref_bcd(x, 5));
    check("en_b", en_b, ref_en(x, 5));
    @(posedge clk); #1;
    check("rdy_b", rdy_b, 1);
  endtask

  task automatic count_dones_a(input int cycles);
    dones = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (done_a) dones++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; val_a = '0; val_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy_a", rdy_a, 1);
    check("rst_done_a", done_a, 0);
    check("rst_bcd_a", bcd_a, 0);
    check("rst_en_a", en_a, 3'b001);
    check("rst_rdy_b", rdy_b, 1);
    check("rst_en_b", en_b, 5'b00001);
    @(negedge clk); rst_n = 1'b1;

    conv_a(8'd255);
    conv_a(8'd0);
    conv_a(8'd7);
    conv_a(8'd100);

    // a second start mid-conversion must be ignored
    @(negedge clk); start_a = 1'b1; val_a = 8'd42;
    @(posedge clk); #1; start_a = 1'b0;
    dones = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); start_a = (k == 3); if (k == 3) val_a = 8'd99;
      @(posedge clk); #1;
      if (done_a) dones++;
    end
    check("ign_dones", dones, 1);
    check("ign_bcd", bcd_a, 12'h042);

    // reset mid-conversion aborts without a done pulse
    @(negedge clk); start_a = 1'b1; val_a = 8'd200;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_done", done_a, 0);
    check("abort_bcd", bcd_a, 0);
    check("abort_en", en_a, 3'b001);
    check("abort_rdy", rdy_a, 1);
    @(negedge clk); rst_n = 1'b1;
    count_dones_a(12);
    check("abort_nodone", dones, 0);
    conv_a(8'd13);

    // reset and start together: reset wins
    @(negedge clk); rst_n = 1'b0; start_a = 1'b1; val_a = 8'd50;
    @(posedge clk); #1;
    check("rs_rdy", rdy_a, 1);
    @(negedge clk); rst_n = 1'b1; start_a = 1'b0;
    count_dones_a(12);
    check("rs_nodone", dones, 0);
    check("rs_bcd", bcd_a, 0);

    conv_b(16'd65535);
    conv_b(16'd1000);
    conv_b(16'd0);
    repeat (4) conv_b(16'($urandom));
    repeat (4) conv_a(8'($urandom));

    // back-to-back with start held high and value changing every cycle
    nxt = 0;
    last_bcd = bcd_a;
    last_en = en_a;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); start_a = 1'b1; val_a = 8'($urandom);
      @(posedge clk);
      if (c == nxt) begin
        vq.push_back(val_a);
        acc.push_back(c);
        nxt += 10;
      end
      #1;
      exp_done = acc.size() > 0 && c == acc[0] + 9;
      check("b2b_done", done_a, exp_done);
      if (exp_done) begin
        v = vq.pop_front();
        void'(acc.pop_front());
        last_bcd = ref_bcd(v, 3);
        last_en = ref_en(v, 3);
      end
      check("b2b_bcd", bcd_a, last_bcd);
      check("b2b_en", en_a, last_en);
    end
    @(negedge clk); start_a = 1'b0;
    repeat (12) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
